// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word and cache-line types.
package lc3b_types;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_data;
endpackage

// File: rtl/cache_control.sv
// cache_control: 2-way write-back cache controller; hits complete in one cycle,
// misses optionally write back the dirty victim and then fill it from pmem.
module cache_control
    import lc3b_types::*;
(
    input  logic clk,
    input  logic reset,
    input  logic mem_read,
    input  logic mem_write,
    input  logic hit0,
    input  logic hit1,
    input  logic dirty0,
    input  logic dirty1,
    input  logic lru_out,
    input  logic pmem_resp,
    output logic mem_resp,
    output logic pmem_read,
    output logic pmem_write,
    output logic way_select,
    output logic load_way0,
    output logic load_way1,
    output logic data_in_sel,
    output logic load_dirty,
    output logic dirty_in,
    output logic load_lru,
    output logic lru_in,
    output logic pmem_addr_sel
);
    typedef enum logic [1:0] {S_CHECK, S_WRITEBACK, S_FILL} state_t;

    state_t r_state, w_next;
    logic   r_victim;
    logic   w_req, w_hit, w_miss;

    // Gating with reset keeps every output low while reset is held.
    assign w_req  = (mem_read | mem_write) & ~reset;
    assign w_hit  = hit0 | hit1;
    assign w_miss = (r_state == S_CHECK) & w_req & ~w_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_CHECK;
            r_victim <= 1'b0;
        end else begin
            r_state  <= w_next;
            if (w_miss)
                r_victim <= lru_out;
        end
    end

    always_comb begin
        w_next        = r_state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        way_select    = 1'b0;
        load_way0     = 1'b0;
        load_way1     = 1'b0;
        data_in_sel   = 1'b0;
        load_dirty    = 1'b0;
        dirty_in      = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        pmem_addr_sel = 1'b0;
        if (!reset) begin
            case (r_state)
                S_CHECK: begin
                    if (w_req && w_hit) begin
                        mem_resp   = 1'b1;
                        way_select = ~hit0;
                        load_lru   = 1'b1;
                        lru_in     = hit0;
                        load_way0  = mem_write & hit0;
                        load_way1  = mem_write & ~hit0;
                        load_dirty = mem_write;
                        dirty_in   = mem_write;
                    end else if (w_req) begin
                        w_next = (lru_out ? dirty1 : dirty0) ? S_WRITEBACK : S_FILL;
                    end
                end
                S_WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    way_select    = r_victim;
                    w_next        = pmem_resp ? S_FILL : S_WRITEBACK;
                end
                S_FILL: begin
                    pmem_read   = 1'b1;
                    way_select  = r_victim;
                    load_way0   = pmem_resp & ~r_victim;
                    load_way1   = pmem_resp & r_victim;
                    data_in_sel = pmem_resp;
                    load_dirty  = pmem_resp;
                    w_next      = pmem_resp ? S_CHECK : S_FILL;
                end
                default: w_next = S_CHECK;
            endcase
        end
    end
endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have no parameters; geometry is fixed at 2 ways, 128-bit lines (lc3b_data), 16-bit CPU words (lc3b_word).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 mem_read  input  1  CPU read request, held until mem_resp.
REQ-005 mem_write  input  1  CPU write request, held until mem_resp; never asserted together with mem_read.
REQ-006 hit0 / hit1  input  1 each  tag match and valid for way 0 / way 1 at the indexed set.
REQ-007 dirty0 / dirty1  input  1 each  dirty bit of way 0 / way 1 at the indexed set.
REQ-008 lru_out  input  1  LRU way of the indexed set (0 = way 0 is the victim).
REQ-009 pmem_resp  input  1  physical memory has completed the current line read or write.
REQ-010 mem_resp  output  1  CPU request complete, one-cycle pulse.
REQ-011 pmem_read / pmem_write  output  1 each  line request to physical memory, held until pmem_resp.
REQ-012 way_select  output  1  way driving the byte/word output mux and the load target.
REQ-013 load_way0 / load_way1  output  1 each  write enable for data, tag and valid of that way.
REQ-014 data_in_sel  output  1  0 = merge CPU write data into the line, 1 = take the line from pmem.
REQ-015 load_dirty / dirty_in  output  1 each  dirty-bit write enable and value for the way_select way.
REQ-016 load_lru / lru_in  output  1 each  LRU write enable and new LRU value.
REQ-017 pmem_addr_sel  output  1  0 = CPU address, 1 = victim tag + index (writeback address).

Function
REQ-018 SHALL implement the states S_CHECK, S_WRITEBACK and S_FILL; all outputs default to 0 in every state unless listed below.
REQ-019 In S_CHECK with a request and hit0|hit1, mem_resp=1 in the same cycle (hit latency 1 cycle); way_select = hit way; hit0 takes priority if both are set; load_lru=1; lru_in = ~hit way.
REQ-020 A write hit additionally SHALL assert load_way<hit>=1, data_in_sel=0, load_dirty=1 and dirty_in=1 in that cycle.
REQ-021 Miss in S_CHECK: next state S_WRITEBACK if the victim (lru_out) way is dirty, else S_FILL; mem_resp stays 0.
REQ-022 S_WRITEBACK: pmem_write=1, pmem_addr_sel=1, way_select=lru_out; on pmem_resp go to S_FILL, else stay.
REQ-023 S_FILL: pmem_read=1, pmem_addr_sel=0, way_select=lru_out; on pmem_resp assert load_way<victim>=1, data_in_sel=1, load_dirty=1, dirty_in=0, then go to S_CHECK.
REQ-024 After S_FILL, S_CHECK SHALL re-evaluate the request and service it as a hit; a clean-miss read completes 1 cycle after the fill pmem_resp.
REQ-025 The victim SHALL be sampled from lru_out on the S_CHECK miss cycle and held in a register through S_WRITEBACK and S_FILL.
REQ-026 If the request is withdrawn during S_WRITEBACK or S_FILL, the controller SHALL complete the memory transaction, return to S_CHECK and assert no mem_resp.
REQ-027 pmem_resp in S_CHECK SHALL be ignored; pmem_read and pmem_write SHALL never be high together.
REQ-028 No request in S_CHECK: stay, all outputs 0.

Reset
REQ-029 reset SHALL immediately force state S_CHECK and clear the victim register, giving all outputs 0 while reset is high.
REQ-030 Reset asserted during S_WRITEBACK or S_FILL SHALL abandon the transaction and drop pmem_read/pmem_write asynchronously.

Structure
REQ-031 lc3b_word and lc3b_data SHALL come from the shared package lc3b_types; the state enum SHALL be local to cache_control.
REQ-032 Single module with no sub-module; tag/data arrays, comparators and the output mux stay in the cache datapath.

Verification
REQ-033 Read hit: mem_read=1, hit1=1 -> same cycle mem_resp=1, way_select=1, load_lru=1, lru_in=0.
REQ-034 Write hit way 0: mem_write=1, hit0=1 -> load_way0=1, data_in_sel=0, load_dirty=1, dirty_in=1, mem_resp=1.
REQ-035 Clean miss: mem_read=1, no hit, lru_out=1, dirty1=0 -> S_FILL, pmem_read=1; pmem_resp after 5 cycles -> load_way1=1, data_in_sel=1; bench then drives hit1=1 -> mem_resp on the next cycle.
REQ-036 Dirty miss: lru_out=0, dirty0=1 -> pmem_write=1, pmem_addr_sel=1 until pmem_resp, then pmem_read=1, then hit completion.
REQ-037 Reset during S_FILL with pmem_read=1 -> pmem_read=0 immediately, state S_CHECK, mem_resp=0.
REQ-038 Both hit0=1 and hit1=1 on a read -> way_select=0 and lru_in=1.
